// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the initiator and the responder side.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } spi_state_t;

    localparam int   SPI_DATA_W = 4;
    localparam logic SPI_CPOL   = 1'b0;

    // Counter width for a modulus of n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// Parallel-side handshake plus the serial pins of the SPI initiator.
interface spi_master_if import spi_pkg::*; #(
    parameter int DATA_W = SPI_DATA_W
);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              ready;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              sclk;
    logic              mosi;
    logic              ss_n;
    logic              miso;

    modport master (
        input  start, tx_data, miso,
        output ready, done, rx_data, sclk, mosi, ss_n
    );

    modport slave (
        output start, tx_data, miso,
        input  ready, done, rx_data, sclk, mosi, ss_n
    );
endinterface

// File: rtl/spi_sclk_gen.sv
// Half-period tick generator: tick fires every CLK_DIV enabled cycles.
module spi_sclk_gen import spi_pkg::*; #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int            CW   = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (!en || cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = en && (cnt_reg == LAST);
endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator: serialises a word MSB-first and captures miso into rx_data.
module spi_master import spi_pkg::*; #(
    parameter int DATA_W  = SPI_DATA_W,
    parameter int CLK_DIV = 4
) (
    input logic          clk,
    input logic          rst,
    spi_master_if.master bus
);
    localparam int            BW       = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W);

    spi_state_t        state_reg;
    logic [DATA_W-1:0] tx_reg;
    logic [DATA_W-1:0] rx_reg;
    logic [DATA_W-1:0] tx_next;
    logic [DATA_W-1:0] rx_next;
    logic [BW-1:0]     bit_cnt_reg;
    logic              ready_reg;
    logic              done_reg;
    logic [DATA_W-1:0] rx_data_reg;
    logic              sclk_reg;
    logic              mosi_reg;
    logic              ss_n_reg;
    logic              sclk_en;
    logic              tick;

    // Half-period timing runs only while the slave is selected, so the first
    // tick lands CLK_DIV cycles after ss_n falls.
    assign sclk_en = !ss_n_reg;

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (sclk_en),
        .tick (tick)
    );

    assign tx_next[0] = 1'b0;
    assign rx_next[0] = bus.miso;
    for (genvar gi = 1; gi < DATA_W; gi++) begin : g_shift
        assign tx_next[gi] = tx_reg[gi-1];
        assign rx_next[gi] = rx_reg[gi-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            tx_reg      <= '0;
            rx_reg      <= '0;
            bit_cnt_reg <= '0;
            ready_reg   <= 1'b1;
            done_reg    <= 1'b0;
            rx_data_reg <= '0;
            sclk_reg    <= SPI_CPOL;
            mosi_reg    <= 1'b0;
            ss_n_reg    <= 1'b1;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        tx_reg      <= bus.tx_data;
                        rx_reg      <= '0;
                        bit_cnt_reg <= '0;
                        state_reg   <= SETUP;
                    end
                end
                SETUP: begin
                    ready_reg <= 1'b0;
                    ss_n_reg  <= 1'b0;
                    mosi_reg  <= tx_reg[DATA_W-1];
                    if (tick) begin
                        sclk_reg    <= 1'b1;
                        rx_reg      <= rx_next;
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!sclk_reg) begin
                            sclk_reg    <= 1'b1;
                            rx_reg      <= rx_next;
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end else begin
                            sclk_reg <= 1'b0;
                            // The final fall leaves mosi on the last bit through HOLD.
                            if (bit_cnt_reg == LAST_BIT) begin
                                state_reg <= HOLD;
                            end else begin
                                tx_reg   <= tx_next;
                                mosi_reg <= tx_next[DATA_W-1];
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        state_reg   <= IDLE;
                        ss_n_reg    <= 1'b1;
                        ready_reg   <= 1'b1;
                        done_reg    <= 1'b1;
                        rx_data_reg <= rx_reg;
                        mosi_reg    <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.ready   = ready_reg;
    assign bus.done    = done_reg;
    assign bus.rx_data = rx_data_reg;
    assign bus.sclk    = sclk_reg;
    assign bus.mosi    = mosi_reg;
    assign bus.ss_n    = ss_n_reg;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: scoreboarded rx words plus edge-accurate timing checks.
module tb_spi_master;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic loop_en;
    logic miso_fix;

    always #5 clk = ~clk;

    spi_master_if #(.DATA_W(4)) bus ();
    spi_master_if #(.DATA_W(8)) bus8 ();

    assign bus.miso  = loop_en ? bus.mosi : miso_fix;
    assign bus8.miso = bus8.mosi;

    spi_master #(.DATA_W(4), .CLK_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    spi_master #(.DATA_W(8), .CLK_DIV(1)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.master)
    );

    int         checks = 0;
    int         errors = 0;
    logic [3:0] sb4[$];
    logic [7:0] sb8[$];
    int         edge_n = 0;
    int         rises  = 0;
    int         falls  = 0;
    int         dones  = 0;
    logic [3:0] cap    = 4'h0;
    logic       sclk_prev = 1'b0;
    logic       ss_prev   = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Observation point for the 4-bit DUT, called at each falling clk edge.
    task automatic obs4();
        logic [3:0] e;
        if (bus.sclk && !sclk_prev && !bus.ss_n) begin
            rises++;
            cap = {cap[2:0], bus.mosi};
        end
        if (!bus.ss_n && ss_prev) falls++;
        if (bus.done) begin
            dones++;
            if (sb4.size() == 0) begin
                chk("sb4_depth", 32'(sb4.size()), 32'd1);
            end else begin
                e = sb4.pop_front();
                chk("rx_data", 32'(bus.rx_data), 32'(e));
            end
        end
        sclk_prev = bus.sclk;
        ss_prev   = bus.ss_n;
    endtask

    task automatic step4();
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        obs4();
    endtask

    // Runs one transfer from a falling clk edge; optionally pulses start at edge ign.
    task automatic xfer4(input logic [3:0] data, input logic [3:0] exp_rx, input int ign, input string tag);
        int r0;
        int d0;
        r0 = rises;
        d0 = dones;
        bus.tx_data = data;
        bus.start   = 1'b1;
        sb4.push_back(exp_rx);
        @(posedge clk);
        edge_n = 0;
        #1;
        bus.start   = 1'b0;
        bus.tx_data = ~data;
        @(negedge clk);
        obs4();
        chk({tag, "_ssn_e0"}, 32'(bus.ss_n), 32'd1);
        while (dones == d0 && edge_n < 200) begin
            if (ign > 0 && edge_n == ign - 1) bus.start = 1'b1;
            else if (ign > 0 && edge_n == ign) bus.start = 1'b0;
            step4();
            if (edge_n == 1) chk({tag, "_e1"}, 32'({bus.ready, bus.ss_n, bus.mosi}), 32'({2'b00, data[3]}));
        end
        chk({tag, "_done_edge"}, 32'(edge_n), 32'd37);
        chk({tag, "_rises"}, 32'(rises - r0), 32'd4);
        chk({tag, "_idle_at_done"}, 32'({bus.ready, bus.ss_n, bus.sclk, bus.mosi}), 32'b1100);
        $display("xfer tag=%s tx=%h rx=%h done_edge=%0d", tag, data, bus.rx_data, edge_n);
    endtask

    initial begin
        int         f0;
        int         d0;
        int         g;
        int         e8;
        logic       seen;
        logic [7:0] exp8;

        rst           = 1'b1;
        loop_en       = 1'b1;
        miso_fix      = 1'b0;
        bus.start     = 1'b0;
        bus.tx_data   = 4'h0;
        bus8.start    = 1'b0;
        bus8.tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset with no start.
        for (int i = 0; i < 50; i++) begin
            step4();
            chk("idle", 32'({bus.ready, bus.done, bus.ss_n, bus.sclk, bus.mosi, bus.rx_data}), 32'b1_0_1_0_0_0000);
        end

        // Loopback 1011.
        xfer4(4'b1011, 4'b1011, 0, "loop_b");
        chk("mosi_bits", 32'(cap), 32'b1011);

        // miso tied high, stray start at edge 10, then no further transfer.
        loop_en  = 1'b0;
        miso_fix = 1'b1;
        f0 = falls;
        d0 = dones;
        xfer4(4'h0, 4'hF, 10, "miso1");
        repeat (60) step4();
        chk("no_requeue_falls", 32'(falls - f0), 32'd1);
        chk("no_requeue_dones", 32'(dones - d0), 32'd1);
        chk("rx_held", 32'(bus.rx_data), 32'hF);

        // Back-to-back with start held high.
        loop_en = 1'b1;
        d0 = dones;
        bus.tx_data = 4'h5;
        bus.start   = 1'b1;
        sb4.push_back(4'h5);
        sb4.push_back(4'hA);
        @(posedge clk);
        edge_n = 0;
        #1;
        bus.tx_data = 4'hA;
        @(negedge clk);
        obs4();
        while (dones == d0 && edge_n < 200) step4();
        chk("b2b_first_edge", 32'(edge_n), 32'd37);
        g = 1;
        for (int i = 0; i < 10; i++) begin
            step4();
            if (!bus.ss_n) break;
            g++;
        end
        bus.start = 1'b0;
        chk("b2b_gap", 32'(g), 32'd2);
        while (dones < d0 + 2 && edge_n < 300) step4();
        chk("b2b_second_edge", 32'(edge_n), 32'd75);
        chk("b2b_dones", 32'(dones - d0), 32'd2);
        chk("b2b_sb_empty", 32'(sb4.size()), 32'd0);
        $display("xfer tag=b2b rx=%h done_edge=%0d", bus.rx_data, edge_n);

        // Asynchronous reset mid-transfer.
        d0 = dones;
        bus.tx_data = 4'h6;
        bus.start   = 1'b1;
        @(posedge clk);
        edge_n = 0;
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        obs4();
        while (edge_n < 19) step4();
        chk("rst_pre_ssn", 32'(bus.ss_n), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async", 32'({bus.ss_n, bus.sclk, bus.ready, bus.done, bus.mosi, bus.rx_data}), 32'b1_0_1_0_0_0000);
        @(negedge clk);
        obs4();
        repeat (3) step4();
        rst = 1'b0;
        repeat (40) step4();
        chk("rst_no_done", 32'(dones - d0), 32'd0);
        $display("xfer tag=rst_abort rx=%h", bus.rx_data);
        xfer4(4'h9, 4'h9, 0, "post_rst");

        // 8-bit, CLK_DIV=1 loopback.
        bus8.tx_data = 8'hC3;
        bus8.start   = 1'b1;
        sb8.push_back(8'hC3);
        @(posedge clk);
        e8 = 0;
        #1;
        bus8.start   = 1'b0;
        bus8.tx_data = 8'h00;
        seen = 1'b0;
        while (!seen && e8 < 100) begin
            @(posedge clk);
            e8++;
            @(negedge clk);
            if (bus8.done) begin
                seen = 1'b1;
                exp8 = sb8.pop_front();
                chk("rx8", 32'(bus8.rx_data), 32'(exp8));
            end
        end
        chk("done_edge8", 32'(e8), 32'd18);
        $display("xfer tag=w8 tx=c3 rx=%h done_edge=%0d", bus8.rx_data, e8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_master.md
# spi_master

Initiator side of the 4-bit SPI link used on the board: accepts a parallel nibble from local logic, serialises it MSB-first on `mosi` with a generated `sclk` and active-low `ss_n`, and captures the responder's `miso` bits into `rx_data`. It sits between the control logic (switches/FSM) and the SPI slave that drives the 7-segment display and PWM. SPI mode 0 (CPOL=0, CPHA=0): data is driven on falling edges and sampled on rising edges of `sclk`.

## Interface
- `DATA_W`, 4: bits per transaction.
- `CLK_DIV`, 4: `sclk` half-period in `clk` cycles; legal range is ≥1.
- `clk`  in  1  system clock; all state is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  transfer request; sampled only while `ready`=1.
- `tx_data`  in  DATA_W  word to send; latched on the accept edge.
- `ready`  out  1  idle and able to accept `start`.
- `done`  out  1  one-cycle pulse when a transfer completes.
- `rx_data`  out  DATA_W  last word received; held until the next `done`.
- `sclk`  out  1  serial clock, idle low.
- `mosi`  out  1  serial data out.
- `ss_n`  out  1  slave select, active low.
- `miso`  in  1  serial data in.

## Operation
- Reset values: `ready`=1, `done`=0, `rx_data`=0, `sclk`=0, `mosi`=0, `ss_n`=1. The FSM returns to IDLE and the counters clear.
- FSM states:
  - IDLE: `ready`=1. On `start`, latch `tx_data` into the shift register and go to SETUP.
  - SETUP: `ss_n`=0, `mosi`=`tx[DATA_W-1]`, `sclk`=0. Wait `CLK_DIV` cycles, then go to SHIFT.
  - SHIFT: `sclk` toggles every `CLK_DIV` cycles.
    - On each rising edge, shift `miso` into the receive register at the LSB.
    - On each falling edge except the last, shift `tx` left and drive the new MSB on `mosi`.
    - The bit counter counts rising edges. After `DATA_W` rises and the final fall, go to HOLD.
  - HOLD: `sclk`=0 and `ss_n`=0 for `CLK_DIV` cycles, then go to IDLE. On that transition:
    - `ss_n`=1, `ready`=1, `done`=1 for exactly one cycle.
    - `rx_data` is loaded from the receive register.
    - `mosi` returns to 0.
- `start` while `ready`=0 is ignored; it is not queued.
- `tx_data` changes after the accept edge have no effect on the current transfer.
- The half-period counter width is `$clog2(CLK_DIV)`, minimum 1 bit. The bit counter width is `$clog2(DATA_W+1)`.
- Reset mid-transfer (asynchronous):
  - `ss_n` rises and `sclk` drops immediately.
  - `rx_data` clears to 0 and `done` does not pulse.

## Timing
- Edge 0 is the accept edge (`start`=1, `ready`=1 sampled). Let H=`CLK_DIV` and N=`DATA_W`.
- `ready` falls, `ss_n` falls and `mosi`=MSB on edge 1.
- Rising `sclk` occurs on edges 1+H+2H·k, for k=0..N-1. Falling `sclk` occurs on edges 1+2H·(k+1).
- `ss_n` rises, `done` pulses, `ready` rises and `rx_data` updates on edge 1+2H·N+H. With the defaults this is edge 37.
- `start` asserted in the `done` cycle is accepted on the following edge. `ss_n` is high for at least 2 `clk` cycles between back-to-back transfers.
- `mosi` is stable for ≥H cycles before and after every rising `sclk` edge.
- With CLK_DIV=1, `sclk` = `clk`/2 and the same formulas hold.

## Structure
- Package `spi_pkg`:
  - `spi_state_t` enum {IDLE, SETUP, SHIFT, HOLD}.
  - `SPI_DATA_W`=4 default and `SPI_CPOL`=0 localparam.
  - Shared with the slave side.
- One sub-module, `spi_sclk_gen`: a half-period tick counter with `en` and a `tick` output. The FSM toggles `sclk` on `tick`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset held, then released with no `start`: `ready`=1, `ss_n`=1, `sclk`=0, `mosi`=0, `rx_data`=0 for 50 cycles.
- Loopback (`miso`=`mosi`), `tx_data`=4'b1011, defaults:
  - `mosi` sampled at `sclk` rises is 1,0,1,1.
  - `done` pulses on edge 37 and `rx_data`=4'b1011.
  - Exactly 4 rising `sclk` edges occur while `ss_n`=0.
- `miso` tied 1, `tx_data`=4'h0: `rx_data`=4'hF after `done`. `start` pulsed at edge 10 is ignored, with no second transfer.
- Back-to-back transfers: `start` held high continuously with `tx_data`=4'h5 then 4'hA:
  - Two transfers occur, with a `ss_n` gap of 2 cycles.
  - With loopback, `rx_data` reads 4'h5 then 4'hA.
- `rst` asserted at edge 20 of a transfer: `ss_n`=1 and `sclk`=0 immediately, `done` never pulses, and the next transfer completes correctly.
- CLK_DIV=1, DATA_W=8, loopback 8'hC3: `done` on edge 1+16+1=18 and `rx_data`=8'hC3.
